// File: rtl/tb_pkg.sv
// Shared types and default sizing for the transport-block scheduler.
package tb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        PAD  = 2'd2
    } state_t;

    localparam int DEF_SIZE_TBLCK   = 480;
    localparam int DEF_TIME_TO_WAIT = 5;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin selector: picks the first requester after the last grant, wrapping around.
module rr_arbiter #(
    parameter int N  = 2,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] last,
    output logic [IW-1:0] grant,
    output logic          valid
);

    int idx;

    // Scan from farthest to nearest so the nearest requester after 'last' wins.
    always_comb begin
        grant = '0;
        valid = 1'b0;
        idx   = 0;
        for (int k = N; k >= 1; k--) begin
            idx = (int'(last) + k) % N;
            if (req[idx]) begin
                grant = IW'(idx);
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/tb_scheduler.sv
// Transport-block scheduler: grants one byte-stream source per block, forwards its bytes
// with zero latency and pads with 0x00 when the granted source starves.
module tb_scheduler
    import tb_pkg::*;
#(
    parameter  int N_SRC        = 2,
    parameter  int SIZE_TBLCK   = DEF_SIZE_TBLCK,
    parameter  int TIME_TO_WAIT = DEF_TIME_TO_WAIT,
    localparam int IW           = (N_SRC > 1) ? $clog2(N_SRC) : 1,
    localparam int CW           = $clog2(SIZE_TBLCK),
    localparam int SW           = $clog2(TIME_TO_WAIT) + 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N_SRC-1:0]      src_val,
    input  logic [N_SRC-1:0][7:0] src_data,
    output logic [N_SRC-1:0]      src_req,
    input  logic                  dreq,
    output logic                  oval,
    output logic [7:0]            odata,
    output logic                  osop,
    output logic                  oeop,
    output logic [IW-1:0]         osrc
);

    state_t        state;
    logic [CW-1:0] count;
    logic [SW-1:0] starve;
    logic [IW-1:0] last_grant;
    logic [IW-1:0] grant;
    logic [IW-1:0] arb_grant;
    logic          arb_valid;
    logic          last_byte;
    logic          xfer;

    rr_arbiter #(
        .N  (N_SRC),
        .IW (IW)
    ) u_arb (
        .req   (src_val),
        .last  (last_grant),
        .grant (arb_grant),
        .valid (arb_valid)
    );

    assign last_byte = (count == CW'(SIZE_TBLCK - 1));
    assign xfer      = dreq & oval;
    assign osrc      = grant;

    // Outputs follow the state combinationally so granted bytes pass through with no latency.
    always_comb begin
        src_req = '0;
        oval    = 1'b0;
        odata   = 8'h00;
        case (state)
            XFER: begin
                src_req[grant] = dreq;
                oval           = src_val[grant];
                odata          = src_data[grant];
            end
            PAD: begin
                oval = 1'b1;
            end
            default: begin
            end
        endcase
        osop = oval & (count == '0);
        oeop = oval & last_byte;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            count      <= '0;
            starve     <= '0;
            last_grant <= IW'(N_SRC - 1);
            grant      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (arb_valid) begin
                        grant <= arb_grant;
                        state <= XFER;
                    end
                end
                XFER, PAD: begin
                    if (xfer) begin
                        starve <= '0;
                        if (last_byte) begin
                            count      <= '0;
                            last_grant <= grant;
                            state      <= IDLE;
                        end else begin
                            count <= count + 1'b1;
                        end
                    end else if (state == XFER && dreq) begin
                        // Downstream is ready but the source is not: count toward padding.
                        if (starve == SW'(TIME_TO_WAIT - 1)) begin
                            starve <= '0;
                            state  <= PAD;
                        end else begin
                            starve <= starve + 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_tb_scheduler.sv
// Directed bench for tb_scheduler (2 sources, 8-byte blocks, 5-cycle starvation limit).
module tb_tb_scheduler;

    localparam int N   = 2;
    localparam int SZ  = 8;
    localparam int TTW = 5;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic [N-1:0]      src_val;
    logic [N-1:0][7:0] src_data;
    logic [N-1:0]      src_req;
    logic              dreq;
    logic              oval;
    logic [7:0]        odata;
    logic              osop;
    logic              oeop;
    logic [0:0]        osrc;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        int src;
        int data;
        bit sop;
        bit eop;
        int cyc;
    } ent_t;

    ent_t log_q[$];
    int   ptr [N];
    bit   cons [N];
    int   cyc = 0;

    bit m_busy, m_pad;
    int m_src, m_cnt, m_starve, m_last;

    tb_scheduler #(
        .N_SRC        (N),
        .SIZE_TBLCK   (SZ),
        .TIME_TO_WAIT (TTW)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .src_val  (src_val),
        .src_data (src_data),
        .src_req  (src_req),
        .dreq     (dreq),
        .oval     (oval),
        .odata    (odata),
        .osop     (osop),
        .oeop     (oeop),
        .osrc     (osrc)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Source i streams bytes (i+1)*0x40 + n, n advancing each time a byte is consumed.
    task automatic drive();
        for (int i = 0; i < N; i++) src_data[i] = 8'((i + 1) * 64 + ptr[i]);
    endtask

    task automatic reset_ptrs();
        for (int i = 0; i < N; i++) ptr[i] = 0;
        drive();
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) if (cons[i]) ptr[i]++;
        drive();
    endtask

    task automatic wait_log(input int n, input int budget, input bit toggle, input string name);
        int b = 0;
        while (log_q.size() < n && b < budget) begin
            if (toggle) dreq = ~dreq;
            tick();
            b++;
        end
        chk(name, int'(log_q.size() >= n), 1);
    endtask

    // Reference model: block-level view of grant, byte position, starvation and padding.
    always @(negedge clk) begin
        logic [N-1:0] e_req;
        bit           e_val, e_sop, e_eop, found;
        int           e_data;
        ent_t         e;
        cyc++;
        for (int i = 0; i < N; i++) cons[i] = 1'b0;
        if (!rst) begin
            m_busy = 0; m_pad = 0; m_src = 0; m_cnt = 0; m_starve = 0; m_last = N - 1;
            chk("rst_src_req", src_req, 0);
            chk("rst_oval", oval, 0);
            chk("rst_odata", odata, 0);
            chk("rst_osop", osop, 0);
            chk("rst_oeop", oeop, 0);
            chk("rst_osrc", osrc, 0);
        end else begin
            e_req  = '0;
            e_val  = 0;
            e_data = 0;
            if (m_busy && m_pad) begin
                e_val = 1;
            end else if (m_busy) begin
                e_req[m_src] = dreq;
                e_val        = src_val[m_src];
                e_data       = src_data[m_src];
            end
            e_sop = e_val && (m_cnt == 0);
            e_eop = e_val && (m_cnt == SZ - 1);
            chk("src_req", src_req, e_req);
            chk("oval", oval, e_val);
            chk("odata", odata, e_data);
            chk("osop", osop, e_sop);
            chk("oeop", oeop, e_eop);
            chk("osrc", osrc, m_src);
            if (!m_busy) begin
                found = 0;
                for (int k = 1; k <= N; k++) begin
                    if (!found && src_val[(m_last + k) % N]) begin
                        found  = 1;
                        m_src  = (m_last + k) % N;
                        m_busy = 1;
                    end
                end
            end else if (dreq) begin
                if (e_val) begin
                    e.src = m_src; e.data = e_data; e.sop = e_sop; e.eop = e_eop; e.cyc = cyc;
                    log_q.push_back(e);
                    if (!m_pad) cons[m_src] = 1'b1;
                    m_starve = 0;
                    if (m_cnt == SZ - 1) begin
                        m_busy = 0; m_pad = 0; m_cnt = 0; m_last = m_src;
                    end else begin
                        m_cnt++;
                    end
                end else begin
                    m_starve++;
                    if (m_starve == TTW) begin
                        m_pad    = 1;
                        m_starve = 0;
                    end
                end
            end
        end
    end

    initial begin
        dreq    = 1'b0;
        src_val = '1;
        reset_ptrs();
        repeat (3) tick();
        chk("lit_rst_oval", oval, 0);
        chk("lit_rst_req", src_req, 0);
        src_val = '0;
        rst     = 1'b1;
        tick();

        // Both sources always valid: blocks alternate 0, 1, 0.
        reset_ptrs();
        log_q.delete();
        dreq    = 1'b1;
        src_val = 2'b11;
        wait_log(24, 60, 1'b0, "alt_done");
        src_val = 2'b00;
        repeat (3) tick();
        chk("alt_b0_src", log_q[0].src, 0);
        chk("alt_b0_data", log_q[0].data, 8'h40);
        chk("alt_b0_sop", log_q[0].sop, 1);
        chk("alt_b0_eop", log_q[7].eop, 1);
        chk("alt_b0_last", log_q[7].data, 8'h47);
        chk("alt_b1_src", log_q[8].src, 1);
        chk("alt_b1_data", log_q[8].data, 8'h80);
        chk("alt_gap", log_q[8].cyc - log_q[7].cyc, 2);
        chk("alt_b2_src", log_q[16].src, 0);
        chk("alt_b2_data", log_q[16].data, 8'h48);
        chk("alt_b2_eop", log_q[23].eop, 1);
        chk("alt_count", log_q.size(), 24);

        // Source 0 supplies three bytes then starves: five idle cycles, then padding.
        reset_ptrs();
        log_q.delete();
        src_val = 2'b01;
        wait_log(3, 20, 1'b0, "starve_3");
        src_val = 2'b00;
        wait_log(8, 40, 1'b0, "starve_done");
        repeat (2) tick();
        chk("starve_b2", log_q[2].data, 8'h42);
        chk("starve_gap", log_q[3].cyc - log_q[2].cyc, 6);
        chk("pad_b3", log_q[3].data, 0);
        chk("pad_b7", log_q[7].data, 0);
        chk("pad_eop", log_q[7].eop, 1);
        chk("pad_idle_oval", oval, 0);

        // dreq toggling every cycle: every byte exactly once, in order.
        reset_ptrs();
        log_q.delete();
        src_val = 2'b10;
        wait_log(8, 60, 1'b1, "tog_done");
        src_val = 2'b00;
        dreq    = 1'b1;
        repeat (3) tick();
        chk("tog_count", log_q.size(), 8);
        for (int k = 0; k < 8; k++) chk("tog_data", log_q[k].data, 8'h80 + k);
        chk("tog_sop", log_q[0].sop, 1);
        chk("tog_eop", log_q[7].eop, 1);

        // Source 1 becomes valid mid-block of source 0: waits for the next grant.
        reset_ptrs();
        log_q.delete();
        src_val = 2'b01;
        wait_log(2, 20, 1'b0, "mid_2");
        src_val = 2'b11;
        wait_log(16, 60, 1'b0, "mid_done");
        src_val = 2'b00;
        repeat (3) tick();
        for (int k = 0; k < 8; k++) chk("mid_src0", log_q[k].src, 0);
        chk("mid_eop", log_q[7].eop, 1);
        chk("mid_next_src", log_q[8].src, 1);
        chk("mid_next_data", log_q[8].data, 8'h80);
        chk("mid_next_sop", log_q[8].sop, 1);

        // Reset in the middle of a source-1 block; source 0 must win afterwards.
        reset_ptrs();
        log_q.delete();
        src_val = 2'b01;
        wait_log(8, 30, 1'b0, "pre_done");
        src_val = 2'b11;
        log_q.delete();
        wait_log(4, 20, 1'b0, "rst_mid_4");
        chk("rst_mid_src", log_q[0].src, 1);
        #2;
        rst = 1'b0;
        #1;
        chk("async_oval", oval, 0);
        chk("async_req", src_req, 0);
        chk("async_osrc", osrc, 0);
        chk("async_osop", osop, 0);
        chk("async_odata", odata, 0);
        tick();
        rst = 1'b1;
        log_q.delete();
        wait_log(8, 30, 1'b0, "post_done");
        src_val = 2'b00;
        repeat (3) tick();
        chk("post_src", log_q[0].src, 0);
        chk("post_sop", log_q[0].sop, 1);
        chk("post_data", log_q[0].data, 8'h48);
        chk("post_eop", log_q[7].eop, 1);
        chk("post_count", log_q.size(), 8);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/tb_scheduler.md
TB_SCHEDULER -- requirements
Module: tb_scheduler

Interface
REQ-001 SHALL have parameter N_SRC, default 2, number of byte-stream requesters (2..4).
REQ-002 SHALL have parameter SIZE_TBLCK, default 480, transport block length in bytes.
REQ-003 SHALL have parameter TIME_TO_WAIT, default 5, consecutive starved cycles before padding starts.
REQ-004 SHALL have port clk  in  1  single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have port src_val  in  N_SRC  per-source byte valid.
REQ-007 SHALL have port src_data  in  N_SRC x 8  per-source byte.
REQ-008 SHALL have port src_req  out  N_SRC  per-source read strobe; byte consumed when src_req[i] & src_val[i].
REQ-009 SHALL have port dreq  in  1  downstream ready.
REQ-010 SHALL have port oval  out  1  output byte valid.
REQ-011 SHALL have port odata  out  8  output byte.
REQ-012 SHALL have port osop  out  1  high with first byte of block.
REQ-013 SHALL have port oeop  out  1  high with byte SIZE_TBLCK-1 of block.
REQ-014 SHALL have port osrc  out  clog2(N_SRC)  index of granted source, stable for whole block.

Function
REQ-015 SHALL implement FSM states IDLE, XFER, PAD.
REQ-016 In IDLE, a grant SHALL be taken on any cycle when some src_val is high; winner chosen round-robin, starting search at (last_grant+1) mod N_SRC; XFER entered next cycle.
REQ-017 In IDLE, src_req, oval, osop and oeop SHALL all be 0.
REQ-018 In XFER, src_req[g] SHALL equal dreq; all other src_req SHALL be 0.
REQ-019 In XFER, oval SHALL equal src_val[g] and odata SHALL equal src_data[g], combinationally (zero latency).
REQ-020 A byte SHALL count as transferred when dreq & oval; the byte counter (0..SIZE_TBLCK-1) SHALL advance only on transfer.
REQ-021 osop SHALL be oval & (count==0); oeop SHALL be oval & (count==SIZE_TBLCK-1).
REQ-022 The starve counter SHALL increment each XFER cycle with dreq & ~src_val[g], clear on any transfer, and hold while dreq is low.
REQ-023 When the starve counter reaches TIME_TO_WAIT-1 and is incremented, the FSM SHALL enter PAD next cycle and clear the counter.
REQ-024 In PAD, oval SHALL be 1, odata SHALL be 0x00 and all src_req SHALL be 0; count advances on dreq.
REQ-025 On transfer of byte SIZE_TBLCK-1 (XFER or PAD), count SHALL wrap to 0, last_grant SHALL be set to g, and the FSM SHALL return to IDLE.
REQ-026 A grant SHALL never change mid-block; newly valid sources wait for IDLE.
REQ-027 Padding SHALL never start at count==0 because a block is only granted on src_val.
REQ-028 If dreq is low, FSM state, count and starve counter SHALL all hold.

Reset
REQ-029 Assertion of rst SHALL immediately force state IDLE, count 0, starve counter 0, and last_grant N_SRC-1, so source 0 wins first.
REQ-030 During reset, src_req, oval, osop and oeop SHALL be 0, odata SHALL be 0x00 and osrc SHALL be 0.
REQ-031 Reset mid-block SHALL abandon the block; after release, no completion of the partial block SHALL occur.

Structure
REQ-032 Package tb_pkg SHALL hold the FSM state enum and the default SIZE_TBLCK/TIME_TO_WAIT constants.
REQ-033 The round-robin selector SHALL be sub-module rr_arbiter (request vector, last grant in; grant index and valid out).

Verification
REQ-034 Verify: N_SRC=2, SIZE_TBLCK=8, src0 and src1 always valid, dreq=1 -> blocks alternate src0, src1, src0; each block is 8 bytes with osop on byte 0 and oeop on byte 7.
REQ-035 Verify: src0 supplies 3 bytes then drops src_val, TIME_TO_WAIT=5 -> after 5 starved cycles oval=1, odata=0x00 for the remaining 5 bytes, then oeop and IDLE.
REQ-036 Verify: dreq toggles 1/0 every cycle through a block -> exactly 8 transfers and no duplicated or skipped byte.
REQ-037 Verify: src1 raises valid mid src0 block -> osrc stays 0 until oeop, and src1 is granted on the next IDLE.
REQ-038 Verify: rst asserted at count=4 -> outputs 0 asynchronously; after release, the first block is granted to src0 with osop at count 0.
